// File: rtl/rr_capture_arbiter_pkg.sv
// Shared types and width helpers for the round-robin capture arbiter.
package rr_capture_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_HOLD_MAX = 3;

  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Beat counter must represent HOLD_MAX itself.
  function automatic int beat_w(input int hold_max);
    return ($clog2(hold_max + 1) < 1) ? 1 : $clog2(hold_max + 1);
  endfunction

endpackage

// File: rtl/rr_capture_arbiter_if.sv
// Requester-side bundle of the capture arbiter; master = requesters, slave = arbiter.
// Handshake: req[i] is a level request; gnt[i] (registered) means beat i is captured
// at the next edge whenever req[i] is still high on that edge.
interface rr_capture_arbiter_if
  import rr_capture_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) ();
  localparam int W = idx_w(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] data;
  logic [N_REQ-1:0] lock;
  logic [N_REQ-1:0] gnt;
  logic [W-1:0]     owner;
  logic             O;
  logic             O_valid;
  state_t           state;

  modport master (output req, data, lock, input gnt, owner, O, O_valid, state);
  modport slave  (input req, data, lock, output gnt, owner, O, O_valid, state);
endinterface

// File: rtl/rr_capture_arbiter_pick.sv
// Combinational rotating-priority picker: first set req bit scanning from ptr upward, wrapping.
module rr_pick
  import rr_capture_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic             found,
  output logic [W-1:0]     idx
);
  logic [W:0]   sum;
  logic [W-1:0] cand;

  // Scan from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (W+1)'(i);
      if (sum >= (W+1)'(N_REQ)) sum = sum - (W+1)'(N_REQ);
      cand = sum[W-1:0];
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/rr_capture_arbiter.sv
// Round-robin arbiter sharing one registered capture flop among N_REQ requesters,
// with lock-based holds bounded to HOLD_MAX beats per ownership.
module rr_capture_arbiter
  import rr_capture_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input logic               CLK,
  input logic               ASYNCRESETN,
  rr_capture_arbiter_if.slave bus
);
  localparam int W  = idx_w(N_REQ);
  localparam int BW = beat_w(HOLD_MAX);
  localparam int CW = idx_w(N_REQ) + 2;

  state_t         state_q, state_d;
  logic [W-1:0]   owner_q, owner_d, ptr_q, ptr_d;
  logic [W-1:0]   rel_ptr, pick_ptr, pick_idx;
  logic [BW-1:0]  beats_q, beats_d;
  logic           pick_found, own_req, hold;
  logic           o_q, o_valid_q;

  assign own_req  = bus.req[owner_q];
  assign rel_ptr  = (owner_q == W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  // In BUSY the picker always evaluates the release case; it is ignored on a hold.
  assign pick_ptr = (state_q == BUSY) ? rel_ptr : ptr_q;
  assign hold     = (state_q == BUSY) && own_req && bus.lock[owner_q]
                    && (beats_q < BW'(HOLD_MAX));

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          owner_d = pick_idx;
          beats_d = BW'(1);
        end
      end
      BUSY: begin
        if (hold) begin
          beats_d = beats_q + 1'b1;
        end else begin
          ptr_d = rel_ptr;
          if (pick_found) begin
            owner_d = pick_idx;
            beats_d = BW'(1);
          end else begin
            state_d = IDLE;
            beats_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      o_q       <= 1'b0;
      o_valid_q <= 1'b0;
    end else if (state_q == BUSY && own_req) begin
      o_q       <= bus.data[owner_q];
      o_valid_q <= 1'b1;
    end else begin
      o_valid_q <= 1'b0;
    end
  end

  always_comb begin
    bus.gnt = '0;
    if (state_q == BUSY) bus.gnt[owner_q] = 1'b1;
    bus.owner   = owner_q;
    bus.O       = o_q;
    bus.O_valid = o_valid_q;
    bus.state   = state_q;
  end

  // Per-requester wait age while locks are all low; feeds the starvation check.
  logic [CW-1:0] wait_cnt [N_REQ];
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < N_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!bus.req[i] || bus.gnt[i] || (|bus.lock)) wait_cnt[i] <= '0;
        else if (wait_cnt[i] != '1)                  wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    $onehot0(bus.gnt));

  a_capture: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    (|(bus.gnt & bus.req)) |-> ##1 bus.O_valid);

  a_hold_limit: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    (state_q == BUSY) |-> (beats_q != '0 && beats_q <= BW'(HOLD_MAX)));

  for (genvar g = 0; g < N_REQ; g++) begin : g_fair
    a_no_starve: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      wait_cnt[g] <= CW'(N_REQ));
  end
endmodule

// File: tb/tb_rr_capture_arbiter.sv
// Directed + random bench for rr_capture_arbiter (N_REQ=4 and N_REQ=3 instances)
// against a rule-level reference model.
module tb_rr_capture_arbiter;
  import rr_capture_pkg::*;

  logic CLK = 1'b0;
  logic ASYNCRESETN;
  always #5 CLK = ~CLK;

  rr_capture_arbiter_if #(.N_REQ(4)) bus4 ();
  rr_capture_arbiter_if #(.N_REQ(3)) bus3 ();

  rr_capture_arbiter #(.N_REQ(4), .HOLD_MAX(3)) u_dut4 (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .bus         (bus4)
  );

  rr_capture_arbiter #(.N_REQ(3), .HOLD_MAX(3)) u_dut3 (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .bus         (bus3)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int owner;
    bit busy;
    int ptr;
    int beats;
    bit o;
    bit ov;
  } mdl_t;

  mdl_t m4, m3;

  function automatic mdl_t mdl_reset();
    mdl_t x;
    x.owner = 0; x.busy = 1'b0; x.ptr = 0; x.beats = 0; x.o = 1'b0; x.ov = 1'b0;
    return x;
  endfunction

  function automatic int pick(input int n, input int p, input logic [15:0] r);
    for (int off = 0; off < n; off++) begin
      int j;
      j = (p + off) % n;
      if (r[j[3:0]]) return j;
    end
    return -1;
  endfunction

  function automatic mdl_t mnext(input mdl_t m, input int n, input int hmax,
                                 input logic [15:0] r, input logic [15:0] d,
                                 input logic [15:0] l);
    mdl_t x;
    int   w;
    int   k;
    x = m;
    k = m.owner;
    if (m.busy) begin
      x.ov = r[k[3:0]];
      if (r[k[3:0]]) x.o = d[k[3:0]];
      if (r[k[3:0]] && l[k[3:0]] && m.beats < hmax) begin
        x.beats = m.beats + 1;
      end else begin
        x.ptr = (k + 1) % n;
        w = pick(n, x.ptr, r);
        if (w >= 0) begin
          x.owner = w; x.beats = 1;
        end else begin
          x.busy = 1'b0; x.beats = 0;
        end
      end
    end else begin
      x.ov = 1'b0;
      w = pick(n, m.ptr, r);
      if (w >= 0) begin
        x.busy = 1'b1; x.owner = w; x.beats = 1;
      end
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag);
    chk({tag, ".gnt4"},   32'(bus4.gnt),     m4.busy ? (32'd1 << m4.owner) : 32'd0);
    chk({tag, ".owner4"}, 32'(bus4.owner),   32'(m4.owner));
    chk({tag, ".O4"},     32'(bus4.O),       32'(m4.o));
    chk({tag, ".Ov4"},    32'(bus4.O_valid), 32'(m4.ov));
    chk({tag, ".state4"}, 32'(bus4.state),   32'(m4.busy));
  endtask

  task automatic check3(input string tag);
    chk({tag, ".gnt3"},   32'(bus3.gnt),     m3.busy ? (32'd1 << m3.owner) : 32'd0);
    chk({tag, ".owner3"}, 32'(bus3.owner),   32'(m3.owner));
    chk({tag, ".O3"},     32'(bus3.O),       32'(m3.o));
    chk({tag, ".Ov3"},    32'(bus3.O_valid), 32'(m3.ov));
  endtask

  // Inputs are applied just after an edge; outputs are checked 1 time unit after the next edge.
  task automatic step4(input logic [3:0] r, input logic [3:0] d, input logic [3:0] l,
                       input string tag);
    bus4.req = r; bus4.data = d; bus4.lock = l;
    bus3.req = '0; bus3.data = '0; bus3.lock = '0;
    m4 = mnext(m4, 4, 3, {12'b0, r}, {12'b0, d}, {12'b0, l});
    m3 = mnext(m3, 3, 3, 16'b0, 16'b0, 16'b0);
    @(posedge CLK);
    #1;
    check4(tag);
  endtask

  task automatic step3(input logic [2:0] r, input logic [2:0] d, input logic [2:0] l,
                       input string tag);
    bus3.req = r; bus3.data = d; bus3.lock = l;
    bus4.req = '0; bus4.data = '0; bus4.lock = '0;
    m3 = mnext(m3, 3, 3, {13'b0, r}, {13'b0, d}, {13'b0, l});
    m4 = mnext(m4, 4, 3, 16'b0, 16'b0, 16'b0);
    @(posedge CLK);
    #1;
    check3(tag);
  endtask

  initial begin
    logic [3:0] rr, dd, ll;
    logic [2:0] g3_seq [5];
    g3_seq[0] = 3'b001; g3_seq[1] = 3'b010; g3_seq[2] = 3'b100;
    g3_seq[3] = 3'b001; g3_seq[4] = 3'b010;

    // Reset
    ASYNCRESETN = 1'b0;
    bus4.req = '0; bus4.data = '0; bus4.lock = '0;
    bus3.req = '0; bus3.data = '0; bus3.lock = '0;
    m4 = mdl_reset();
    m3 = mdl_reset();
    #1;
    chk("rst.gnt",   32'(bus4.gnt),     32'd0);
    chk("rst.owner", 32'(bus4.owner),   32'd0);
    chk("rst.O",     32'(bus4.O),       32'd0);
    chk("rst.Ov",    32'(bus4.O_valid), 32'd0);
    chk("rst.gnt3",  32'(bus3.gnt),     32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
    check4("post_rst");

    // Single requester
    step4(4'b0001, 4'b0001, 4'b0000, "single1");
    chk("single.gnt_first", 32'(bus4.gnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step4(4'b0001, 4'b0001, 4'b0000, "single");
      chk("single.gnt", 32'(bus4.gnt), 32'h1);
      chk("single.O",   32'(bus4.O), 32'h1);
      chk("single.Ov",  32'(bus4.O_valid), 32'h1);
    end
    step4(4'b0000, 4'b0000, 4'b0000, "drain");
    step4(4'b0000, 4'b0000, 4'b0000, "drain");

    // All four requesting, data varies per cycle
    for (int i = 0; i < 8; i++) begin
      step4(4'b1111, 4'($urandom_range(0, 15)), 4'b0000, "all4");
      chk("all4.no_gap", 32'(bus4.gnt == 4'b0000), 32'd0);
    end
    step4(4'b0000, 4'b0000, 4'b0000, "drain");
    step4(4'b0000, 4'b0000, 4'b0000, "drain");

    // Lock limit: requester 0 locks but may hold only HOLD_MAX beats
    for (int i = 0; i < 5; i++) step4(4'b0011, 4'b0001, 4'b0001, "lock");
    step4(4'b0000, 4'b0000, 4'b0000, "drain");
    step4(4'b0000, 4'b0000, 4'b0000, "drain");

    // Withdrawal: owner 2 drops req while lock[2] stays high
    step4(4'b0100, 4'b0100, 4'b0100, "wd_grant");
    chk("wd.gnt", 32'(bus4.gnt), 32'h4);
    step4(4'b0100, 4'b0100, 4'b0100, "wd_hold");
    chk("wd.O_cap", 32'(bus4.O), 32'h1);
    step4(4'b1000, 4'b0000, 4'b0100, "wd_drop");
    chk("wd.Ov_drop", 32'(bus4.O_valid), 32'h0);
    chk("wd.O_keep",  32'(bus4.O), 32'h1);
    chk("wd.gnt_mv",  32'(bus4.gnt), 32'h8);

    // Reset mid-burst while gnt=0100
    step4(4'b0100, 4'b0100, 4'b0100, "mr_grant");
    chk("mr.gnt_pre", 32'(bus4.gnt), 32'h4);
    #2;
    ASYNCRESETN = 1'b0;
    m4 = mdl_reset();
    m3 = mdl_reset();
    #1;
    chk("mr.gnt", 32'(bus4.gnt),     32'd0);
    chk("mr.O",   32'(bus4.O),       32'd0);
    chk("mr.Ov",  32'(bus4.O_valid), 32'd0);
    bus4.lock = '0;
    @(negedge CLK) ASYNCRESETN = 1'b1;
    m4 = mnext(m4, 4, 3, 16'h0004, 16'h0004, 16'h0000);
    @(posedge CLK);
    #1;
    check4("mr_regrant");
    chk("mr.gnt_again", 32'(bus4.gnt), 32'h4);
    step4(4'b0000, 4'b0000, 4'b0000, "drain");
    step4(4'b0000, 4'b0000, 4'b0000, "drain");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rr = 4'($urandom_range(0, 15));
      dd = 4'($urandom);
      ll = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      step4(rr, dd, ll, "rand");
    end
    step4(4'b0000, 4'b0000, 4'b0000, "drain");
    step4(4'b0000, 4'b0000, 4'b0000, "drain");

    // Non-power-of-two instance
    for (int i = 0; i < 5; i++) begin
      step3(3'b111, 3'($urandom_range(0, 7)), 3'b000, "np2");
      chk("np2.gnt_seq", 32'(bus3.gnt), 32'(g3_seq[i]));
      chk("np2.owner_rng", 32'(bus3.owner < 2'd3), 32'd1);
    end
    for (int i = 0; i < 60; i++) begin
      step3(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom_range(0, 7)), "np2_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
